dm_responder: RTL and testbench
===============================

# dm_responder

Memory-side responder for the CPU's data-memory port. It accepts one load or store request at a time over a valid/ready handshake, applies a configurable number of wait states, and performs a word-addressed RAM access with byte-enable writes. It returns read data plus an error flag over a second valid/ready handshake. It replaces the zero-latency data memory when the datapath is moved to a stalling, handshaked memory interface.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address width; RAM depth = 2^ADDR_WIDTH 32-bit words
- WAIT_CYCLES, 2, wait states inserted between request acceptance and the RAM access (0 allowed)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  requester presents a request
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  store byte enables; bit i writes bits [8i+7:8i]
- resp_valid  out  1  response available
- resp_ready  in  1  requester accepts the response
- resp_rdata  out  32  load data (0 for stores and errors)
- resp_err  out  1  request was misaligned or out of range

## Operation
- State machine with four states.
  - IDLE: req_ready=1; all other outputs hold their last values, with resp_valid=0.
  - WAIT: counts down the wait states.
  - ACCESS: one cycle; performs the RAM access.
  - RESP: resp_valid=1 until the response is accepted.
- Transitions:
  - IDLE -> WAIT on req_valid&&req_ready, or IDLE -> ACCESS if WAIT_CYCLES=0. On that edge, latch req_write, req_addr, req_wdata and req_be, and load the counter with WAIT_CYCLES.
  - WAIT: counter decrements each cycle. Go to ACCESS on the edge where the counter reaches 0.
  - ACCESS -> RESP unconditionally. On this edge, commit the write or register the read word into resp_rdata, and register resp_err.
  - RESP -> IDLE on resp_valid&&resp_ready. Otherwise hold RESP with resp_rdata and resp_err stable.
- Error condition uses the latched address:
  - Error if addr[1:0]!=0, or if addr[31:ADDR_WIDTH+2] is not 0.
  - On error: no RAM write, resp_rdata=0, resp_err=1.
- Word index = addr[ADDR_WIDTH+1:2].
- Store behaviour:
  - Only bytes with be=1 change.
  - be=4'b0000 is a legal no-op store with resp_err=0.
  - resp_rdata=0.
- Load behaviour:
  - Returns the full word; req_be is ignored.
- Only one request is outstanding at a time. req_ready=0 in WAIT, ACCESS and RESP. Inputs in those states are ignored.
- RAM contents are not cleared by reset. Locations never written read as X in simulation.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
- Latency: a request accepted at edge k gives resp_valid=1 after edge k+WAIT_CYCLES+1.
  - WAIT_CYCLES=2: resp_valid rises after edge k+3.
  - WAIT_CYCLES=0: resp_valid rises after edge k+1.
- Throughput: the earliest next acceptance is the edge after the response handshake. The minimum period is WAIT_CYCLES+3 cycles per request.
- req_ready is combinational from state only, never from req_valid. resp_valid is a registered state decode.
- resp_ready held high before resp_valid does not shorten latency. Holding resp_ready=0 stalls indefinitely with no data change.
- Reset mid-operation:
  - Reset asserted in WAIT or RESP returns to IDLE next edge; a pending store is discarded.
  - Reset on the ACCESS edge wins: no RAM write occurs.
- Read-after-write: a load accepted after a store's response returns the updated word.

## Test plan
- Reset, then store addr 0x0000_0010, wdata 0xDEAD_BEEF, be 4'b1111; then load 0x10. Required: store resp_err=0, rdata=0; load rdata=0xDEAD_BEEF, resp_err=0, resp_valid rising exactly 3 cycles after acceptance (WAIT_CYCLES=2).
- Word 0x10 = 0xDEAD_BEEF, store wdata 0x1122_3344 with be 4'b0101, then load. Required: rdata=0xDE22_BE44.
- Misaligned load 0x0000_0012, and out-of-range store 0x0000_1000 with ADDR_WIDTH=10. Required: resp_err=1 and rdata=0 for both; word 0 is unchanged afterwards.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP while toggling req_valid. Required: resp_valid stays 1, rdata is stable, req_ready=0, and no second request is accepted.
- Reset during WAIT of a store of 0xCAFE_F00D to 0x20 (word previously 0x0). Required: all outputs return to reset values next cycle; a subsequent load of 0x20 returns 0x0.
- WAIT_CYCLES=0 build with back-to-back requests and resp_ready tied high. Required: resp_valid one cycle after each acceptance and a new acceptance every 3 cycles.

Source files
------------

// File: rtl/dm_responder.sv
// Handshaked data-memory responder: one outstanding load/store, programmable
// wait states, word-addressed RAM with byte-enable writes and error reporting.
module dm_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    // state    | meaning
    // S_IDLE   | ready for a request; response outputs hold last values
    // S_WAIT   | counting down wait states for the latched request
    // S_ACCESS | single-cycle RAM read or byte-masked write
    // S_RESP   | response presented until resp_ready

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  mem_we;
    logic                  acc_err;
    logic [ADDR_WIDTH-1:0] word_idx;

    logic [31:0] mem_q [2**ADDR_WIDTH];

    assign word_idx = addr_q[ADDR_WIDTH+1:2];
    assign acc_err  = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = CW'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
                // leave on the edge where the counter lands on zero
                if (cnt_q <= CW'(1)) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (acc_err) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end else if (wr_q) begin
                    mem_we  = 1'b1;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end else begin
                    rdata_d = mem_q[word_idx];
                    err_d   = 1'b0;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM is never cleared; reset only blocks a write landing on the same edge
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: WAIT_CYCLES=2 instance for functional
// cases, WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dm_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // WAIT_CYCLES=2 instance
    logic        reset = 1'b1, req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    // WAIT_CYCLES=0 instance
    logic        reset_z = 1'b1, req_valid_z = 1'b0, req_write_z = 1'b0, resp_ready_z = 1'b1;
    logic [31:0] req_addr_z = '0, req_wdata_z = '0;
    logic [3:0]  req_be_z = '0;
    logic        req_ready_z, resp_valid_z, resp_err_z;
    logic [31:0] resp_rdata_z;

    dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_z (
        .clock(clock), .reset(reset_z),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
        .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_be(req_be_z),
        .resp_valid(resp_valid_z), .resp_ready(resp_ready_z),
        .resp_rdata(resp_rdata_z), .resp_err(resp_err_z)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_acc = 0, n_resp = 0, n_resp_z = 0;
    logic [32:0] exp_q[$], exp_z_q[$];
    int acc_q[$], acc_z_q[$], acc_z_hist[$];
    logic prev_v = 1'b0, prev_v_z = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired, got no event expected one", name);
    endtask

    // acceptance watchers record the edge number at which a request is taken
    always @(negedge clock) begin
        if (reset) acc_q.delete();
        else if (req_valid && req_ready) begin
            acc_q.push_back(cyc + 1);
            n_acc++;
        end
        if (!reset_z && req_valid_z && req_ready_z) begin
            acc_z_q.push_back(cyc + 1);
            acc_z_hist.push_back(cyc + 1);
        end
    end

    // monitors: latency on resp_valid rise, data on handshake
    always @(negedge clock) begin
        logic [32:0] e;
        if (resp_valid && !prev_v) begin
            if (acc_q.size() == 0) fail_bound("unexpected_resp");
            else check("latency", cyc - acc_q.pop_front(), 3);
        end
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) fail_bound("scoreboard_empty");
            else begin
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e[31:0]);
                check("resp_err", 32'(resp_err), 32'(e[32]));
            end
            n_resp++;
        end
        prev_v = resp_valid;
    end

    always @(negedge clock) begin
        logic [32:0] e;
        if (resp_valid_z && !prev_v_z) begin
            if (acc_z_q.size() == 0) fail_bound("z_unexpected_resp");
            else check("z_latency", cyc - acc_z_q.pop_front(), 1);
        end
        if (resp_valid_z && resp_ready_z) begin
            if (exp_z_q.size() == 0) fail_bound("z_scoreboard_empty");
            else begin
                e = exp_z_q.pop_front();
                check("z_resp_rdata", resp_rdata_z, e[31:0]);
                check("z_resp_err", 32'(resp_err_z), 32'(e[32]));
            end
            n_resp_z++;
        end
        prev_v_z = resp_valid_z;
    end

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        bit ok = 0;
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_be = be;
        for (int t = 0; t < 50; t++) begin
            @(negedge clock);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) fail_bound("accept_timeout");
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int start = n_resp;
        bit ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clock);
            if (n_resp > start) begin ok = 1; break; end
        end
        if (!ok) fail_bound("resp_timeout");
    endtask

    task automatic req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err);
        exp_q.push_back({exp_err, exp_rd});
        issue(wr, a, wd, be);
        wait_resp();
    endtask

    logic        z_wr [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] z_ad [4] = '{32'h4, 32'h8, 32'h4, 32'h8};
    logic [31:0] z_wd [4] = '{32'hA5A5_A5A5, 32'h0102_0304, 32'h0, 32'h0};
    logic [31:0] z_ex [4] = '{32'h0, 32'h0, 32'hA5A5_A5A5, 32'h0102_0304};

    initial begin
        int acc_before;
        bit ok;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0; reset_z = 1'b0;
        @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", 32'(resp_err), 0);
        check("z_rst_req_ready", 32'(req_ready_z), 1);
        check("z_rst_resp_valid", 32'(resp_valid_z), 0);

        req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        req(1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
        req(1'b0, 32'h10, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0);
        req(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
        req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);
        req(1'b1, 32'h0, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
        req(1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1);
        req(1'b1, 32'h1000, 32'hAAAA_AAAA, 4'hF, 32'h0, 1'b1);
        req(1'b0, 32'h0, 32'h0, 4'h0, 32'h1234_5678, 1'b0);

        // backpressure in RESP with req_valid toggling
        resp_ready = 1'b0;
        exp_q.push_back({1'b0, 32'hDE22_BE44});
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            if (resp_valid) begin ok = 1; break; end
        end
        if (!ok) fail_bound("bp_resp_timeout");
        acc_before = n_acc;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            req_valid = ~req_valid; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'hF;
            @(negedge clock);
            check("bp_resp_valid", 32'(resp_valid), 1);
            check("bp_resp_rdata", resp_rdata, 32'hDE22_BE44);
            check("bp_req_ready", 32'(req_ready), 0);
        end
        check("bp_no_accept", n_acc, acc_before);
        @(posedge clock); #1;
        req_valid = 1'b0; resp_ready = 1'b1;
        wait_resp();

        // reset during WAIT discards the store
        req(1'b1, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0);
        req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);
        issue(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("wrst_req_ready", 32'(req_ready), 1);
        check("wrst_resp_valid", 32'(resp_valid), 0);
        check("wrst_resp_rdata", resp_rdata, 0);
        check("wrst_resp_err", 32'(resp_err), 0);
        repeat (4) @(negedge clock);
        check("wrst_no_resp", 32'(resp_valid), 0);
        req(1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);

        // WAIT_CYCLES=0 back-to-back, resp_ready held high
        for (int i = 0; i < 4; i++) exp_z_q.push_back({1'b0, z_ex[i]});
        @(posedge clock); #1;
        req_valid_z = 1'b1; req_write_z = z_wr[0]; req_addr_z = z_ad[0];
        req_wdata_z = z_wd[0]; req_be_z = 4'hF;
        for (int i = 0; i < 4; i++) begin
            ok = 0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clock);
                if (req_ready_z) begin ok = 1; break; end
            end
            if (!ok) fail_bound("z_accept_timeout");
            @(posedge clock); #1;
            if (i < 3) begin
                req_write_z = z_wr[i+1]; req_addr_z = z_ad[i+1]; req_wdata_z = z_wd[i+1];
            end else begin
                req_valid_z = 1'b0;
            end
        end
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            if (n_resp_z >= 4) begin ok = 1; break; end
        end
        if (!ok) fail_bound("z_resp_timeout");
        if (acc_z_hist.size() != 4) fail_bound("z_accept_count");
        else for (int i = 1; i < 4; i++) check("z_accept_period", acc_z_hist[i] - acc_z_hist[i-1], 3);

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
